uart_tx_fifo: RTL and testbench

Parametrised successor to the single-byte UART transmitter. Generic data width, stop-bit count and baud divisor, plus an internal FIFO so the host can burst bytes without waiting a full frame per byte. Sits between a fabric-side byte producer (debug/capture readout logic) and the board UART_TX pin. Also serves as the bench stimulus driver into UART_RX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, default baud divisor, clog2 helper.
package uart_pkg;

    localparam int unsigned BAUD_115200_100MHZ = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with extended read/write pointers; level, full and empty derive from them.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_115200_100MHZ,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_odd,
`endif
    input  logic                        tx_req,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                        tx_busy,
    output logic                        uart_tx
);
    localparam int unsigned LW    = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = clog2(BAUD_DIV);
    localparam int unsigned IDX_W = clog2(DATA_BITS);

    uart_state_e          state;
    uart_state_e          state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [LW-1:0]        lvl_next;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_done;
    logic                 last_data;
    logic                 last_stop;
    logic                 tx_next;

    assign fifo_push = tx_req && tx_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bit_done  = (baud_cnt == '0);
    assign last_data = bit_done && (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = bit_done && (bit_idx == IDX_W'(STOP_BITS - 1));

    // Ready looks one cycle ahead so a push is never offered into a full FIFO.
    assign lvl_next = fifo_level + LW'(fifo_push) - LW'(fifo_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (bit_done)    state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (last_data) state_next = PARITY;
            PARITY: if (bit_done)  state_next = STOP;
`else
            DATA:   if (last_data) state_next = STOP;
`endif
            STOP:  if (last_stop) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      parity_bit <= 1'b0;
        else if (state == START && bit_done) parity_bit <= (^shreg) ^ parity_odd;
    end
`endif

    always_comb begin
        fifo_pop = 1'b0;
        tx_next  = 1'b1;
        case (state)
            IDLE:   fifo_pop = !fifo_empty;
            START:  tx_next  = 1'b0;
            DATA:   tx_next  = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next  = parity_bit;
`endif
            STOP:   fifo_pop = last_stop && !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= CNT_W'(BAUD_DIV - 1);
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            uart_tx  <= tx_next;
            tx_busy  <= (state != IDLE) || !fifo_empty;
            tx_ready <= (lvl_next != LW'(FIFO_DEPTH));

            if (state == IDLE || bit_done) baud_cnt <= CNT_W'(BAUD_DIV - 1);
            else                           baud_cnt <= baud_cnt - 1'b1;

            if (state_next != state) bit_idx <= '0;
            else if (bit_done)       bit_idx <= bit_idx + 1'b1;

            if (fifo_pop)                     shreg <= fifo_dout;
            else if (state == DATA && bit_done) shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table of single frames plus burst, full, reset and stop/parity sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int FB1 = 11;
    localparam int FB2 = 12;
`else
    localparam int FB1 = 10;
    localparam int FB2 = 11;
`endif
    localparam int FL1 = FB1 * 4;
    localparam int FL2 = FB2 * 4;
    localparam int HN  = 320;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_req;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [2:0] fifo_level;
    logic       tx_busy;
    logic       uart_tx;
    logic       tx_req2;
    logic       tx_ready2;
    logic [7:0] tx_data2;
    logic [4:0] fifo_level2;
    logic       tx_busy2;
    logic       uart_tx2;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd2;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .BAUD_DIV   (4),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
`ifdef UART_TX_PARITY_EN
        .parity_odd (1'b0),
`endif
        .tx_req     (tx_req),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .uart_tx    (uart_tx)
    );

    uart_tx_fifo #(
        .BAUD_DIV   (4),
        .DATA_BITS  (8),
        .STOP_BITS  (2),
        .FIFO_DEPTH (16)
    ) u_dut2 (
        .clk        (clk),
        .reset      (reset),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd2),
`endif
        .tx_req     (tx_req2),
        .tx_ready   (tx_ready2),
        .tx_data    (tx_data2),
        .fifo_level (fifo_level2),
        .tx_busy    (tx_busy2),
        .uart_tx    (uart_tx2)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in send order, bit 0 = start bit
        logic       par;     // even parity of data
    } vec_t;

    vec_t vecs [6];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   par_flip_t = -1;
    logic [7:0] pend  [$];
    logic [7:0] pend2 [$];
    int   accept_t  [$];
    int   accept2_t [$];
    logic h_tx    [HN];
    logic h_rdy   [HN];
    logic h_busy  [HN];
    int   h_lvl   [HN];
    logic h_tx2   [HN];
    logic h_busy2 [HN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit1(input logic [9:0] fr, input logic par, input int k);
`ifdef UART_TX_PARITY_EN
        if (k < 9)  return fr[k];
        if (k == 9) return par;
        return 1'b1;
`else
        if (par === 1'bx) return 1'bx;
        return fr[k];
`endif
    endfunction

    task automatic check_frame1(input string name, input int start, input logic [9:0] fr, input logic par);
        logic [63:0] got;
        logic [63:0] exp;
        got = '0;
        exp = '0;
        for (int k = 0; k < FB1; k++)
            for (int s = 0; s < 4; s++) begin
                got[k*4+s] = h_tx[start + k*4 + s];
                exp[k*4+s] = exp_bit1(fr, par, k);
            end
        check(name, got, exp);
    endtask

    task automatic check_frame2(input string name, input int start, input logic [11:0] seq);
        logic [63:0] got;
        logic [63:0] exp;
        got = '0;
        exp = '0;
        for (int k = 0; k < FB2; k++)
            for (int s = 0; s < 4; s++) begin
                got[k*4+s] = h_tx2[start + k*4 + s];
                exp[k*4+s] = seq[k];
            end
        check(name, got, exp);
    endtask

    // One iteration per clock: drive from the pending queues, clock, then sample outputs.
    task automatic run(input int ncyc);
        logic req_now;
        logic rdy_now;
        logic req2_now;
        logic rdy2_now;
        accept_t.delete();
        accept2_t.delete();
        for (int t = 0; t < ncyc; t++) begin
            req_now  = (pend.size() > 0);
            req2_now = (pend2.size() > 0);
            tx_req   = req_now;
            tx_data  = req_now ? pend[0] : 8'h00;
            tx_req2  = req2_now;
            tx_data2 = req2_now ? pend2[0] : 8'h00;
`ifdef UART_TX_PARITY_EN
            if (t == par_flip_t) parity_odd2 = 1'b1;
`endif
            rdy_now  = tx_ready;
            rdy2_now = tx_ready2;
            @(posedge clk);
            #1;
            if (req_now && rdy_now) begin
                void'(pend.pop_front());
                accept_t.push_back(t);
            end
            if (req2_now && rdy2_now) begin
                void'(pend2.pop_front());
                accept2_t.push_back(t);
            end
            h_tx[t]    = uart_tx;
            h_rdy[t]   = tx_ready;
            h_busy[t]  = tx_busy;
            h_lvl[t]   = int'(fifo_level);
            h_tx2[t]   = uart_tx2;
            h_busy2[t] = tx_busy2;
        end
        tx_req  = 1'b0;
        tx_req2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] burst [5];
        logic [7:0] fill  [6];
        int         maxlvl;
        int         bad_rdy;
        int         lvl4_cnt;

        vecs[0] = '{8'h48, 10'h290, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'hA5, 10'h34A, 1'b0};
        vecs[4] = '{8'h01, 10'h202, 1'b1};
        vecs[5] = '{8'h80, 10'h300, 1'b1};
        burst   = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        fill    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        reset    = 1'b0;
        tx_req   = 1'b1;
        tx_data  = 8'h55;
        tx_req2  = 1'b0;
        tx_data2 = 8'h00;
`ifdef UART_TX_PARITY_EN
        parity_odd2 = 1'b0;
`endif

        // Reset held with a request pending: nothing may be accepted or sent.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("rst_uart_tx", uart_tx, 1'b1);
            check("rst_tx_ready", tx_ready, 1'b0);
        end
        check("rst_busy", tx_busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        reset  = 1'b1;
        tx_req = 1'b0;
        #1;
        check("rel_ready_before_edge", tx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_ready", tx_ready, 1'b1);
        check("rel_ready2", tx_ready2, 1'b1);
        check("rel_level", fifo_level, 3'd0);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            pend.push_back(vecs[v].data);
            run(2 + FL1 + 6);
            check("vec_accept_cnt", accept_t.size(), 1);
            if (accept_t.size() > 0) check("vec_accept_t", accept_t[0], 0);
            check("vec_level_push", h_lvl[0], 1);
            check("vec_level_pop", h_lvl[1], 0);
            check("vec_idle_n1", h_tx[1], 1'b1);
            check_frame1("vec_frame", 2, vecs[v].frame, vecs[v].par);
            check("vec_idle_after", h_tx[2 + FL1], 1'b1);
            check("vec_busy_last", h_busy[1 + FL1], 1'b1);
            check("vec_busy_clear", h_busy[2 + FL1], 1'b0);
        end

        // Burst of five: frames must be contiguous.
        for (int i = 0; i < 5; i++) pend.push_back(burst[i]);
        run(5 * FL1 + 8);
        check("burst_accept_cnt", accept_t.size(), 5);
        for (int i = 0; i < accept_t.size(); i++) check("burst_accept_t", accept_t[i], i);
        maxlvl = 0;
        for (int t = 0; t < 5 * FL1 + 8; t++) if (h_lvl[t] > maxlvl) maxlvl = h_lvl[t];
        check("burst_peak_level", maxlvl, 4);
        for (int i = 0; i < 5; i++)
            check_frame1("burst_frame", 2 + i * FL1, {1'b1, burst[i], 1'b0}, ^burst[i]);
        check("burst_busy_last", h_busy[1 + 5 * FL1], 1'b1);
        check("burst_busy_clear", h_busy[2 + 5 * FL1], 1'b0);

        // Six pushes into a depth-4 FIFO with the request held.
        for (int i = 0; i < 6; i++) pend.push_back(fill[i]);
        run(6 * FL1 + 8);
        check("full_accept_cnt", accept_t.size(), 6);
        for (int i = 0; i < accept_t.size(); i++)
            check("full_accept_t", accept_t[i], (i < 5) ? i : 2 + FL1);
        bad_rdy  = 0;
        lvl4_cnt = 0;
        for (int t = 0; t < 6 * FL1 + 8; t++)
            if (h_lvl[t] == 4) begin
                lvl4_cnt++;
                if (h_rdy[t] !== 1'b0) bad_rdy++;
            end
        check("full_ready_low_at_4", bad_rdy, 0);
        check("full_level4_seen", lvl4_cnt > 0, 1'b1);
        check("full_ready_after_pop", h_rdy[1 + FL1], 1'b1);
        for (int i = 0; i < 6; i++)
            check_frame1("full_frame", 2 + i * FL1, {1'b1, fill[i], 1'b0}, ^fill[i]);
        check("full_busy_clear", h_busy[2 + 6 * FL1], 1'b0);

        // Two stop bits, back-to-back; parity sense changes between frames.
        pend2.push_back(8'h07);
        pend2.push_back(8'h07);
        par_flip_t = 20;
        run(2 * FL2 + 8);
        check("stop2_accept_cnt", accept2_t.size(), 2);
        check("stop2_idle_n1", h_tx2[1], 1'b1);
`ifdef UART_TX_PARITY_EN
        check_frame2("par_even_frame", 2, 12'hE0E);
        check_frame2("par_odd_frame", 2 + FL2, 12'hC0E);
`else
        check_frame2("stop2_frame_a", 2, 12'h60E);
        check_frame2("stop2_frame_b", 2 + FL2, 12'h60E);
`endif
        check("stop2_idle_after", h_tx2[2 + 2 * FL2], 1'b1);
        check("stop2_busy_last", h_busy2[1 + 2 * FL2], 1'b1);
        check("stop2_busy_clear", h_busy2[2 + 2 * FL2], 1'b0);

        // Reset during data bit 3 of 0xF0 with two bytes still queued.
        pend.push_back(8'hF0);
        pend.push_back(8'h11);
        pend.push_back(8'h22);
        run(20);
        check("mr_accept_cnt", accept_t.size(), 3);
        check("mr_line_low", h_tx[19], 1'b0);
        check("mr_level_before", h_lvl[19], 2);
        #2;
        reset = 1'b0;
        #1;
        check("mr_uart_tx", uart_tx, 1'b1);
        check("mr_level", fifo_level, 3'd0);
        check("mr_ready", tx_ready, 1'b0);
        check("mr_busy", tx_busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pend.push_back(8'hA5);
        run(FL1 + 10);
        check("mr_post_accept_cnt", accept_t.size(), 1);
        if (accept_t.size() > 0) check("mr_post_accept_t", accept_t[0], 1);
        check("mr_post_idle", h_tx[2], 1'b1);
        check_frame1("mr_post_frame", 3, 10'h34A, 1'b0);
        check("mr_post_busy_clear", h_busy[3 + FL1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
